// File: rtl/div_pkg.sv
// Shared definitions for the multicycle divider: state encoding and width constants.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift rem:quot left, trial-subtract divisor, set quotient bit.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quot_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quot_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           fits;

    always_comb begin
        shifted = {rem_in, quot_in[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        // shifted < 2*divisor, so the top bit of diff is a clean borrow flag
        fits     = ~diff[WIDTH];
        rem_out  = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quot_out = {quot_in[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/div_unit.sv
// Multicycle signed divider (quotient -> lo_out, remainder -> hi_out), WIDTH restoring steps.
// Optional DIV_UNSIGNED_EN adds the div_unsigned port for DIVU semantics.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_start,
    input  logic [WIDTH-1:0] div_a,
    input  logic [WIDTH-1:0] div_b,
`ifdef DIV_UNSIGNED_EN
    input  logic             div_unsigned,
`endif
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] hi_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_t       state, state_nxt;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] rem, quot, divisor;
    logic [WIDTH-1:0] rem_step, quot_step;
    logic             neg_q, neg_r, zero_flag;
    logic             uns_sel, neg_a, neg_b;
    logic             last_step;

`ifdef DIV_UNSIGNED_EN
    assign uns_sel = div_unsigned;
`else
    assign uns_sel = 1'b0;
`endif

    assign neg_a     = ~uns_sel & div_a[WIDTH-1];
    assign neg_b     = ~uns_sel & div_b[WIDTH-1];
    assign last_step = (count == CNT_W'(WIDTH - 1));

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .quot_in (quot),
        .divisor (divisor),
        .rem_out (rem_step),
        .quot_out(quot_step)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= DIV_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: if (div_start) state_nxt = (div_b == '0) ? DIV_DONE : DIV_RUN;
            DIV_RUN:  if (last_step) state_nxt = DIV_FIX;
            DIV_FIX:  state_nxt = DIV_DONE;
            DIV_DONE: state_nxt = DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            rem       <= '0;
            quot      <= '0;
            divisor   <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            zero_flag <= 1'b0;
            lo_out    <= '0;
            hi_out    <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (div_start) begin
                        zero_flag <= (div_b == '0);
                        count     <= '0;
                        rem       <= '0;
                        quot      <= neg_a ? -div_a : div_a;
                        divisor   <= neg_b ? -div_b : div_b;
                        neg_q     <= neg_a ^ neg_b;
                        neg_r     <= neg_a;
                    end
                end
                DIV_RUN: begin
                    rem   <= rem_step;
                    quot  <= quot_step;
                    count <= count + 1'b1;
                end
                DIV_FIX: begin
                    // -2^(W-1) / -1 wraps back to -2^(W-1) through the negation
                    lo_out <= neg_q ? -quot : quot;
                    hi_out <= neg_r ? -rem : rem;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy     = (state != DIV_IDLE);
        done     = (state == DIV_DONE);
        div_zero = (state == DIV_DONE) & zero_flag;
    end

endmodule
